// File: rtl/hdmi_pattern_sequencer.sv
// Test-pattern source for the 720p DVI/HDMI bring-up path: four patterns selected at frame
// boundaries, with RGB and hs/vs/de registered together so they stay aligned at the TX.
module hdmi_pattern_sequencer #(
  parameter int unsigned H_ACTIVE     = 1280,
  parameter int unsigned V_ACTIVE     = 720,
  parameter int unsigned DWELL_FRAMES = 120,
  parameter bit          VS_POL       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        auto_en,
  input  logic        step,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        de_in,
  input  logic [10:0] active_x,
  input  logic [10:0] active_y,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b,
  output logic [1:0]  pattern_id
);

  localparam logic [10:0] BIT_W  = 11'(H_ACTIVE / 24);
  localparam logic [10:0] BAR_W  = 11'(H_ACTIVE / 8);
  localparam logic [10:0] GRAY_W = 11'(H_ACTIVE / 256);
  localparam logic [10:0] V_MAX  = 11'(V_ACTIVE);
  localparam int unsigned DW     = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);

  logic          vs_d;
  logic          step_pend;
  logic          phase;
  logic [DW-1:0] dwell_cnt;

  logic          frame_start;
  logic          dwell_done;
  logic          advance;
  logic [10:0]   bit_q, bar_q, gray_q;
  logic [4:0]    bit_idx;
  logic [2:0]    bar_idx;
  logic [7:0]    gray;
  logic [23:0]   pix;

  assign frame_start = (vs_in == VS_POL) && (vs_d != VS_POL);
  assign dwell_done  = auto_en && (dwell_cnt == DWELL_LAST);
  assign advance     = frame_start && (step_pend || step || dwell_done);

  // Constant divisors only; quotients are clamped so columns past H_ACTIVE hold the last bar.
  assign bit_q   = active_x / BIT_W;
  assign bar_q   = active_x / BAR_W;
  assign gray_q  = active_x / GRAY_W;
  assign bit_idx = (bit_q > 11'd23) ? 5'd23 : bit_q[4:0];
  assign bar_idx = (bar_q > 11'd7) ? 3'd7 : bar_q[2:0];
  assign gray    = (gray_q > 11'd255) ? 8'hff : gray_q[7:0];

  always_comb begin
    pix = 24'h000000;
    unique case (pattern_id)
      2'd0: pix = 24'h800000 >> bit_idx;
      2'd1: begin
        unique case (bar_idx)
          3'd0: pix = 24'hffffff;
          3'd1: pix = 24'hffff00;
          3'd2: pix = 24'h00ffff;
          3'd3: pix = 24'h00ff00;
          3'd4: pix = 24'hff00ff;
          3'd5: pix = 24'hff0000;
          3'd6: pix = 24'h0000ff;
          3'd7: pix = 24'h000000;
        endcase
      end
      2'd2: pix = {gray, gray, gray};
      2'd3: pix = (active_x[5] ^ active_y[5] ^ phase) ? 24'h000000 : 24'hffffff;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      de_out     <= 1'b0;
      rgb_r      <= 8'h00;
      rgb_g      <= 8'h00;
      rgb_b      <= 8'h00;
      pattern_id <= 2'd0;
      dwell_cnt  <= '0;
      step_pend  <= 1'b0;
      phase      <= 1'b0;
      // Idle at the active level so releasing reset during vs is not a frame start.
      vs_d       <= VS_POL;
    end else begin
      hs_out <= hs_in;
      vs_out <= vs_in;
      de_out <= de_in;
      {rgb_r, rgb_g, rgb_b} <= de_in ? pix : 24'h000000;
      vs_d   <= vs_in;
      if (advance) begin
        pattern_id <= pattern_id + 2'd1;
        dwell_cnt  <= '0;
        step_pend  <= 1'b0;
        phase      <= 1'b0;
      end else begin
        if (step) step_pend <= 1'b1;
        if (!auto_en) dwell_cnt <= '0;
        else if (frame_start) dwell_cnt <= dwell_cnt + 1'b1;
        if (frame_start && pattern_id == 2'd3) phase <= ~phase;
      end
    end
  end

  a_y_in_frame : assert property (@(posedge clk) disable iff (rst) de_in |-> active_y < V_MAX)
    else $error("active_y out of frame");

endmodule

// File: doc/hdmi_pattern_sequencer.md
Name: hdmi_pattern_sequencer

Overview:
Test-pattern controller between the VGA timing generator and the DVI/HDMI TX on the 720p bring-up path.
- Consumes timing signals hs/vs/de and active_x/active_y from the timing generator.
- Selects one of four patterns, changing pattern only at frame boundaries, either on a manual step request or automatically after a dwell count.
- Drives registered RGB plus delay-matched hs/vs/de to the TX.
- Runs entirely in the pixel clock domain.

Parameters:
H_ACTIVE, 1280, active pixels per line
V_ACTIVE, 720, active lines per frame (bounds checking only)
DWELL_FRAMES, 120, frames per pattern in auto mode (>=1)
VS_POL, 1, vs_in active level; frame start = transition into active level

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
auto_en  in  1  1 = auto-advance after DWELL_FRAMES
step  in  1  one-cycle request to advance pattern
hs_in  in  1  timing hs
vs_in  in  1  timing vs
de_in  in  1  timing de
active_x  in  11  pixel column, valid when de_in=1
active_y  in  11  pixel line, valid when de_in=1
hs_out  out  1  hs_in delayed 1 clk
vs_out  out  1  vs_in delayed 1 clk
de_out  out  1  de_in delayed 1 clk
rgb_r  out  8  red
rgb_g  out  8  green
rgb_b  out  8  blue
pattern_id  out  2  current pattern

Behaviour:
Reset (synchronous, rst=1):
- Outputs: all outputs 0, pattern_id=0.
- Internal state: dwell_cnt=0, step_pend=0, checker phase=0.
- vs_d := VS_POL, so no spurious frame start is seen after reset release.

Frame start and pattern advance:
- frame_start = (vs_in==VS_POL) && (vs_d!=VS_POL), with vs_d = vs_in registered.
- step=1 sets step_pend. Several steps before one frame_start collapse to a single advance.
- auto_en=0: dwell_cnt held at 0.
- auto_en=1: dwell_cnt increments on each frame_start.
- dwell_done = auto_en && dwell_cnt==DWELL_FRAMES-1.
- advance = frame_start && (step_pend || step || dwell_done). A step in the same cycle as frame_start counts for that frame_start.
- On advance: pattern_id := pattern_id+1, wrapping 3->0; dwell_cnt := 0; step_pend := 0.
- Pattern therefore never changes mid-active-frame.
- Checker phase toggles on every frame_start while pattern_id==3, and resets to 0 on any advance.

Patterns (pixel value computed from same-cycle inputs, then registered):
- 0 BITWALK: 24 bars of width W=H_ACTIVE/24 (53); b = min(active_x/W, 23); {r,g,b} = 24'h800000 >> b.
- 1 COLORBAR: 8 bars of width H_ACTIVE/8 (160), index clamped to 7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- 2 GRAY: g = min(active_x/(H_ACTIVE/256), 255) (x/5); r=g=b=g.
- 3 CHECKER: c = active_x[5]^active_y[5]^phase; c=0 -> FFFFFF, c=1 -> 000000.

Output rules:
- de_in=0 -> RGB 000000.
- Latency is exactly 1 clk from inputs to rgb_*/hs_out/vs_out/de_out.
- Implementation: no general divider. Bar/gray indices come from per-line column counters that clear when de_in=0, or from constant-divisor logic. Results must match the formulas above exactly for every active_x in 0..H_ACTIVE-1.

Boundary conditions:
- active_x >= H_ACTIVE while de_in=1: clamp behaviour as above.
- Reset mid-frame: takes effect next cycle, and a pending step is discarded.
- step while rst=1: ignored.
- auto_en deasserted mid-dwell: dwell_cnt clears.

Test Plan:
1. After reset, pattern 0, de=1, one output/clk. Per-x checks, each output 1 clk after input:
   - x=0 -> 800000
   - x=53 -> 400000
   - x=1218 -> 000002
   - x=1219 -> 000001
   - x=1279 -> 000001
   - de=0 -> 000000
   - hs/vs/de outputs equal inputs delayed 1 clk
2. step pulse at line 100 of a frame -> pattern_id stays 0 until the next vs active edge, then 1. Three steps within one frame -> pattern_id advances by exactly 1.
3. DWELL_FRAMES=4, auto_en=1, no step -> pattern_id sequence 0,1,2,3,0 changing on every 4th frame_start. Step coincident with frame_start -> advance at that frame_start and dwell restarts.
4. Pattern 1, pixel checks:
   - x=159 -> FFFFFF
   - x=160 -> FFFF00
   - x=1279 -> 000000
5. Pattern 2, pixel checks:
   - x=4 -> 000000
   - x=5 -> 010101
   - x=1279 -> FFFFFF
6. Pattern 3, frame N (phase 0): (31,0) -> FFFFFF; (32,0) -> 000000; (32,32) -> FFFFFF. Frame N+1: (31,0) -> 000000.
7. Reset pulse mid-frame with pattern_id=2 and a pending step -> next cycle: outputs 0, pattern_id=0. No advance at the following vs edge.
